// File: rtl/chnl_rx_buf.sv
// chnl_rx_buf: buffered, length-aware Riffa/CHNL receive channel feeding a user valid/ready stream.
// Latency: a beat accepted on CHNL_RX_DATA is presented on o_data one cycle later at the earliest.
// Backpressure: o_rdy low fills the FIFO; CHNL_RX_DATA_REN drops while it is full, so no beat is lost.

// Small synchronous FIFO: registered storage, no fall-through, count distinguishes full from empty.
module chnl_rx_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until the count says otherwise.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module chnl_rx_buf #(
   parameter int C_PCI_DATA_WIDTH = 32,
   parameter int DEPTH            = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        o_val,
   input  logic                        o_rdy,
   output logic [C_PCI_DATA_WIDTH-1:0] o_data,
   output logic                        o_last,
   output logic [31:0]                 o_len,
   output logic                        o_done,
   output logic                        o_abort,
   output logic                        o_busy,
   output logic                        CHNL_RX_CLK,
   input  logic                        CHNL_RX,
   output logic                        CHNL_RX_ACK,
   input  logic                        CHNL_RX_LAST,
   input  logic [31:0]                 CHNL_RX_LEN,
   input  logic [30:0]                 CHNL_RX_OFF,
   input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
   input  logic                        CHNL_RX_DATA_VALID,
   output logic                        CHNL_RX_DATA_REN
);
   localparam int          WPB   = C_PCI_DATA_WIDTH / 32;
   localparam int          WSH   = $clog2(WPB);
   localparam logic [31:0] WMASK = 32'(WPB - 1);

   typedef enum logic [1:0] {IDLE, OPENING, OPEN, WAIT_CLOSE} state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic [31:0]                 remaining;
   logic [31:0]                 beats_exp;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [C_PCI_DATA_WIDTH:0]   fifo_rdata;
   logic                        unused_ok;

   // Host's offset and last flag carry nothing this receiver needs.
   assign unused_ok = ^{CHNL_RX_LAST, CHNL_RX_OFF};

   // ceil(LEN / WPB) as shift plus round-up bit, so LEN near 2^32 cannot overflow.
   assign beats_exp = (CHNL_RX_LEN >> WSH) + {31'd0, |(CHNL_RX_LEN & WMASK)};

   assign CHNL_RX_CLK = clk;
   assign o_busy      = (state != IDLE);
   assign o_val       = ~fifo_empty;
   assign o_data      = o_val ? fifo_rdata[C_PCI_DATA_WIDTH-1:0] : '0;
   assign o_last      = o_val & fifo_rdata[C_PCI_DATA_WIDTH];

   // Channel state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state plus handshake and status pulses; a last beat landing as CHNL_RX falls still completes.
   always_comb begin
      state_nxt        = state;
      CHNL_RX_ACK      = 1'b0;
      CHNL_RX_DATA_REN = 1'b0;
      o_done           = 1'b0;
      o_abort          = 1'b0;
      case (state)
         IDLE: begin
            if (CHNL_RX) state_nxt = OPENING;
         end
         OPENING: begin
            if (CHNL_RX) begin
               CHNL_RX_ACK = 1'b1;
               state_nxt   = OPEN;
            end else begin
               state_nxt   = IDLE;
            end
         end
         OPEN: begin
            CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID & ~fifo_full & (remaining != 32'd0);
            if (remaining == 32'd0 || (CHNL_RX_DATA_REN && remaining == 32'd1)) begin
               state_nxt = WAIT_CLOSE;
            end else if (!CHNL_RX) begin
               o_abort   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_CLOSE: begin
            if (!CHNL_RX) begin
               o_done    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch length and beat budget at open; count down on every accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_len     <= 32'd0;
         remaining <= 32'd0;
      end else if (state == IDLE && CHNL_RX) begin
         o_len     <= CHNL_RX_LEN;
         remaining <= beats_exp;
      end else if (CHNL_RX_DATA_REN) begin
         remaining <= remaining - 32'd1;
      end
   end

   chnl_rx_fifo #(
      .WIDTH (C_PCI_DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (CHNL_RX_DATA_REN),
      .wr_data ({(remaining == 32'd1), CHNL_RX_DATA}),
      .full    (fifo_full),
      .rd_en   (o_rdy),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty)
   );
endmodule
